// File: rtl/amm_burst_mem_model.sv
// Avalon-MM burst slave memory model with configurable read latency,
// injected waitrequest stalls and a sticky protocol-error flag.
module amm_burst_mem_model #(
    parameter int ADDR_W         = 16,
    parameter int DATA_W         = 32,
    parameter int BURST_W        = 4,
    parameter int MEM_DEPTH_W    = 8,
    parameter int READ_LATENCY   = 2,
    parameter int WAITREQ_PERIOD = 0
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [ADDR_W-1:0]   amm_address_i,
    input  logic                amm_read_i,
    input  logic                amm_write_i,
    input  logic [DATA_W-1:0]   amm_writedata_i,
    input  logic [DATA_W/8-1:0] amm_byteenable_i,
    input  logic [BURST_W-1:0]  amm_burstcount_i,
    output logic                amm_waitrequest_o,
    output logic                amm_readdatavalid_o,
    output logic [DATA_W-1:0]   amm_readdata_o,
    output logic                protocol_err_o
);

    localparam int BE_W  = DATA_W / 8;
    localparam int DEPTH = 1 << MEM_DEPTH_W;
    localparam int CNT_W = (WAITREQ_PERIOD > 2) ? $clog2(WAITREQ_PERIOD) : 1;

    typedef enum logic [1:0] {
        IDLE,
        WR_BURST,
        RD_BURST
    } state_t;

    state_t                   state_q, state_d;
    logic [MEM_DEPTH_W-1:0]   ptr_q, ptr_d;
    logic [BURST_W-1:0]       rem_q, rem_d;
    logic                     alive_q;
    logic [CNT_W-1:0]         cnt_q;
    logic                     err_q;
    logic [DATA_W-1:0]        mem_q [DEPTH];
    logic [READ_LATENCY-1:0]  vld_q;
    logic [DATA_W-1:0]        dat_q [READ_LATENCY];

    logic                     stall;
    logic                     rd_acc, wr_acc;
    logic                     we, re, err_set;
    logic [MEM_DEPTH_W-1:0]   idx, widx, ridx;
    logic                     bc_zero, bc_one;
    logic                     unused_addr;

    assign unused_addr = ^amm_address_i;
    assign idx     = amm_address_i[MEM_DEPTH_W-1:0];
    assign bc_zero = (amm_burstcount_i == '0);
    assign bc_one  = (amm_burstcount_i == BURST_W'(1));

    // Stall injection: one stall cycle whenever the counter hits its top value
    always_comb begin
        stall = 1'b0;
        if (WAITREQ_PERIOD > 0)
            stall = (cnt_q == CNT_W'(WAITREQ_PERIOD - 1));
    end

    // alive_q holds waitrequest high until the first edge after reset release
    assign amm_waitrequest_o = ~alive_q | (state_q == RD_BURST) | stall;
    assign rd_acc = amm_read_i & ~amm_waitrequest_o;
    assign wr_acc = amm_write_i & ~amm_waitrequest_o;

    // Command decode: memory strobes, error detection and FSM next state
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        rem_d   = rem_q;
        we      = 1'b0;
        re      = 1'b0;
        widx    = idx;
        ridx    = idx;
        err_set = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (rd_acc && wr_acc) begin
                    err_set = 1'b1;
                end else if ((rd_acc || wr_acc) && bc_zero) begin
                    err_set = 1'b1;
                end else if (wr_acc) begin
                    we = 1'b1;
                    if (!bc_one) begin
                        state_d = WR_BURST;
                        ptr_d   = idx + MEM_DEPTH_W'(1);
                        rem_d   = amm_burstcount_i - BURST_W'(1);
                    end
                end else if (rd_acc) begin
                    re = 1'b1;
                    if (!bc_one) begin
                        state_d = RD_BURST;
                        ptr_d   = idx + MEM_DEPTH_W'(1);
                        rem_d   = amm_burstcount_i - BURST_W'(1);
                    end
                end
            end
            WR_BURST: begin
                err_set = rd_acc;
                if (wr_acc) begin
                    we    = 1'b1;
                    widx  = ptr_q;
                    ptr_d = ptr_q + MEM_DEPTH_W'(1);
                    rem_d = rem_q - BURST_W'(1);
                    if (rem_q == BURST_W'(1))
                        state_d = IDLE;
                end
            end
            RD_BURST: begin
                re    = 1'b1;
                ridx  = ptr_q;
                ptr_d = ptr_q + MEM_DEPTH_W'(1);
                rem_d = rem_q - BURST_W'(1);
                if (rem_q == BURST_W'(1))
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state, burst pointer, sticky error and reset-release tracking
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            rem_q   <= '0;
            err_q   <= 1'b0;
            alive_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            rem_q   <= rem_d;
            err_q   <= err_q | err_set;
            alive_q <= 1'b1;
        end
    end

    // Free-running mod-N stall counter
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            cnt_q <= '0;
        else if (WAITREQ_PERIOD > 0)
            cnt_q <= stall ? '0 : cnt_q + CNT_W'(1);
    end

    // Storage with byte enables; contents survive reset
    always_ff @(posedge clk_i) begin
        for (int b = 0; b < BE_W; b++)
            if (we && amm_byteenable_i[b])
                mem_q[widx][8*b +: 8] <= amm_writedata_i[8*b +: 8];
    end

    // Read pipeline: stage 0 samples storage before any same-edge write
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_q <= '0;
            for (int i = 0; i < READ_LATENCY; i++)
                dat_q[i] <= '0;
        end else begin
            vld_q[0] <= re;
            dat_q[0] <= re ? mem_q[ridx] : '0;
            for (int i = 1; i < READ_LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
                dat_q[i] <= dat_q[i-1];
            end
        end
    end

    assign amm_readdatavalid_o = vld_q[READ_LATENCY-1];
    assign amm_readdata_o      = dat_q[READ_LATENCY-1];
    assign protocol_err_o      = err_q;

endmodule

// File: tb/tb_amm_burst_mem_model.sv
// Directed bench for amm_burst_mem_model: scoreboard of expected read
// beats (data and arrival cycle) plus a second instance with stalls.
module tb_amm_burst_mem_model;

    localparam int RL = 2;

    logic        clk = 1'b0;
    logic        rst;

    logic [15:0] addr;
    logic        rd, wr;
    logic [31:0] wdata;
    logic [3:0]  be, bc;
    logic        wq, rdv, err;
    logic [31:0] rdata;

    logic [15:0] st_addr;
    logic        st_rd, st_wr;
    logic [31:0] st_wdata;
    logic [3:0]  st_be, st_bc;
    logic        st_wq, st_rdv, st_err;
    logic [31:0] st_rdata;

    amm_burst_mem_model #(
        .ADDR_W(16), .DATA_W(32), .BURST_W(4), .MEM_DEPTH_W(8),
        .READ_LATENCY(RL), .WAITREQ_PERIOD(0)
    ) u_dut (
        .clk_i(clk), .rst_i(rst),
        .amm_address_i(addr), .amm_read_i(rd), .amm_write_i(wr),
        .amm_writedata_i(wdata), .amm_byteenable_i(be),
        .amm_burstcount_i(bc), .amm_waitrequest_o(wq),
        .amm_readdatavalid_o(rdv), .amm_readdata_o(rdata),
        .protocol_err_o(err)
    );

    amm_burst_mem_model #(
        .ADDR_W(16), .DATA_W(32), .BURST_W(4), .MEM_DEPTH_W(8),
        .READ_LATENCY(RL), .WAITREQ_PERIOD(3)
    ) u_st (
        .clk_i(clk), .rst_i(rst),
        .amm_address_i(st_addr), .amm_read_i(st_rd), .amm_write_i(st_wr),
        .amm_writedata_i(st_wdata), .amm_byteenable_i(st_be),
        .amm_burstcount_i(st_bc), .amm_waitrequest_o(st_wq),
        .amm_readdatavalid_o(st_rdv), .amm_readdata_o(st_rdata),
        .protocol_err_o(st_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] d;
        int          c;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] model [256];
    logic [7:0]  wptr;
    int          wrem;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] d, input int c);
        exp_t e;
        e.d = d;
        e.c = c;
        sbq.push_back(e);
    endtask

    // Scoreboard: every valid beat must match the oldest expected beat
    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst && rdv) begin
            if (sbq.size() == 0) begin
                check("rdv_unexpected", 32'd1, 32'd0);
            end else begin
                e = sbq.pop_front();
                check("rdata", rdata, e.d);
                check("rdv_cycle", cyc, e.c);
            end
        end
    end

    // One beat on the main DUT; model and scoreboard updated unless ign
    task automatic beat(input logic r, input logic w, input logic [15:0] a,
                        input logic [31:0] d, input logic [3:0] b,
                        input logic [3:0] n, input bit ign, output int t0);
        bit         ok;
        logic [7:0] p;
        ok = 0;
        rd = r; wr = w; addr = a; wdata = d; be = b; bc = n;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!wq) begin
                ok = 1;
                break;
            end
        end
        check("accept", 32'(ok), 32'd1);
        t0 = cyc;
        if (ok && !ign) begin
            if (w) begin
                if (wrem > 0) begin
                    p = wptr;
                    wptr = wptr + 8'd1;
                    wrem--;
                end else begin
                    p = a[7:0];
                    wptr = p + 8'd1;
                    wrem = int'(n) - 1;
                end
                for (int i = 0; i < 4; i++)
                    if (b[i]) model[p][8*i +: 8] = d[8*i +: 8];
            end
            if (r)
                for (int k = 0; k < int'(n); k++)
                    push(model[8'(a[7:0] + 8'(k))], t0 + RL + k);
        end
        @(posedge clk);
        #1;
        rd = 0; wr = 0;
    endtask

    task automatic read1(input logic [15:0] a, input logic [31:0] exp);
        int t0;
        beat(1, 0, a, 0, 4'hF, 4'd1, 1, t0);
        push(exp, t0 + RL);
    endtask

    task automatic st_beat(input logic r, input logic w, input logic [15:0] a,
                           input logic [31:0] d, input logic [3:0] n);
        bit ok;
        ok = 0;
        st_rd = r; st_wr = w; st_addr = a; st_wdata = d; st_be = 4'hF;
        st_bc = n;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!st_wq) begin
                ok = 1;
                break;
            end
        end
        check("st_accept", 32'(ok), 32'd1);
        @(posedge clk);
        #1;
        st_rd = 0; st_wr = 0;
    endtask

    task automatic do_reset(input int n);
        rst = 1;
        sbq.delete();
        wrem = 0;
        repeat (n) begin
            @(negedge clk);
            check("rst_wq", 32'(wq), 32'd1);
            check("rst_rdv", 32'(rdv), 32'd0);
            check("rst_rdata", rdata, 32'd0);
            check("rst_err", 32'(err), 32'd0);
        end
        @(posedge clk);
        #1;
        rst = 0;
        @(negedge clk);
        check("wq_after_release", 32'(wq), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int          t0;
        logic [8:0]  s;
        int          cnt;
        int          got;
        logic [31:0] st_d [2];

        rst = 1;
        rd = 0; wr = 0; addr = 0; wdata = 0; be = 0; bc = 0;
        st_rd = 0; st_wr = 0; st_addr = 0; st_wdata = 0; st_be = 0; st_bc = 0;
        wrem = 0; wptr = 0;
        #2;
        do_reset(3);

        // Burst write 1..4 at 0x10, burst read back with timing checks
        beat(0, 1, 16'h0010, 32'd1, 4'hF, 4'd4, 0, t0);
        beat(0, 1, 16'hBEEF, 32'd2, 4'hF, 4'd9, 0, t0);
        beat(0, 1, 16'h1234, 32'd3, 4'hF, 4'd1, 0, t0);
        beat(0, 1, 16'h0000, 32'd4, 4'hF, 4'd0, 0, t0);
        check("err_after_wr_burst", 32'(err), 32'd0);
        beat(1, 0, 16'h0010, 32'd0, 4'hF, 4'd4, 0, t0);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            check("wq_rd_burst", 32'(wq), 32'd1);
        end
        @(negedge clk);
        check("wq_after_rd_burst", 32'(wq), 32'd0);
        idle(4);
        check("sb_drain_1", 32'(sbq.size()), 32'd0);

        // Reset in the middle of a read burst
        for (int i = 0; i < 4; i++)
            beat(0, 1, 16'h0020, 32'h20 + 32'(i), 4'hF, 4'd4, 0, t0);
        beat(1, 0, 16'h0020, 32'd0, 4'hF, 4'd4, 0, t0);
        do_reset(3);
        idle(8);

        // Byte-enable merge
        beat(0, 1, 16'h0030, 32'hAABBCCDD, 4'hF, 4'd1, 0, t0);
        beat(0, 1, 16'h0030, 32'h11223344, 4'b0101, 4'd1, 0, t0);
        read1(16'h0030, 32'hAA22CC44);

        // Index wrap at top of storage
        beat(0, 1, 16'h00FF, 32'hA, 4'hF, 4'd2, 0, t0);
        beat(0, 1, 16'h0000, 32'hB, 4'hF, 4'd2, 0, t0);
        read1(16'h0100, 32'hB);
        read1(16'h0000, 32'hB);
        read1(16'h00FF, 32'hA);
        idle(4);
        check("sb_drain_2", 32'(sbq.size()), 32'd0);

        // Burstcount zero: ignored, sticky error
        check("err_before_bc0", 32'(err), 32'd0);
        beat(0, 1, 16'h0030, 32'hDEADBEEF, 4'hF, 4'd0, 1, t0);
        check("err_bc0", 32'(err), 32'd1);
        read1(16'h0030, 32'hAA22CC44);
        idle(5);
        check("err_sticky", 32'(err), 32'd1);
        do_reset(1);

        // Read and write together in IDLE
        beat(1, 1, 16'h0030, 32'h55555555, 4'hF, 4'd1, 1, t0);
        check("err_rw_both", 32'(err), 32'd1);
        read1(16'h0030, 32'hAA22CC44);
        idle(4);
        do_reset(1);

        // Read during a write burst is ignored
        beat(0, 1, 16'h0040, 32'h400, 4'hF, 4'd2, 0, t0);
        beat(1, 0, 16'h0099, 32'd0, 4'hF, 4'd1, 1, t0);
        check("err_rd_in_wr", 32'(err), 32'd1);
        beat(0, 1, 16'h0000, 32'h401, 4'hF, 4'd2, 0, t0);
        read1(16'h0040, 32'h400);
        read1(16'h0041, 32'h401);
        idle(4);
        check("sb_drain_3", 32'(sbq.size()), 32'd0);
        do_reset(1);

        // Stall injection, period 3
        cnt = 0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            s[i] = st_wq;
            cnt += int'(st_wq);
        end
        check("st_stall_count", 32'(cnt), 32'd3);
        for (int i = 0; i < 6; i++)
            check("st_stall_period", 32'(s[i]), 32'(s[i+3]));
        got = 0;
        for (int i = 0; i < 10; i++) begin
            if (st_wq) break;
            @(negedge clk);
        end
        check("st_found_stall", 32'(st_wq), 32'd1);
        st_beat(0, 1, 16'h0060, 32'h111, 4'd2);
        st_beat(0, 1, 16'h0060, 32'h222, 4'd2);
        st_beat(1, 0, 16'h0060, 32'd0, 4'd2);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (st_rdv && got < 2) begin
                st_d[got] = st_rdata;
                got++;
            end
        end
        check("st_beats", 32'(got), 32'd2);
        if (got == 2) begin
            check("st_beat0", st_d[0], 32'h111);
            check("st_beat1", st_d[1], 32'h222);
        end
        check("st_err", 32'(st_err), 32'd0);

        idle(3);
        check("sb_final", 32'(sbq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/amm_burst_mem_model.md
AMM_BURST_MEM_MODEL -- requirements
Module: amm_burst_mem_model

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, word-address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width; a multiple of 8.
REQ-003 SHALL have parameter BURST_W, default 4, burstcount width.
REQ-004 SHALL have parameter MEM_DEPTH_W, default 8, storage index width (2^MEM_DEPTH_W words).
REQ-005 SHALL have parameter READ_LATENCY, default 2, accept-to-first-beat cycles; legal range 1 or more.
REQ-006 SHALL have parameter WAITREQ_PERIOD, default 0; 0 = no injected stalls, N>0 = one stall cycle in every N.
REQ-007 SHALL have port clk_i, input, 1, single clock; all logic on its rising edge.
REQ-008 SHALL have port rst_i, input, 1; the reset is asynchronous and active-high.
REQ-009 SHALL have port amm_address_i, input, ADDR_W, word address of the burst.
REQ-010 SHALL have port amm_read_i, input, 1, read command.
REQ-011 SHALL have port amm_write_i, input, 1, write beat.
REQ-012 SHALL have port amm_writedata_i, input, DATA_W, write data.
REQ-013 SHALL have port amm_byteenable_i, input, DATA_W/8, per-byte write enable.
REQ-014 SHALL have port amm_burstcount_i, input, BURST_W, beats per burst.
REQ-015 SHALL have port amm_waitrequest_o, output, 1, slave stall.
REQ-016 SHALL have port amm_readdatavalid_o, output, 1, read beat valid.
REQ-017 SHALL have port amm_readdata_o, output, DATA_W, read beat data.
REQ-018 SHALL have port protocol_err_o, output, 1, sticky protocol-violation flag.

Function
REQ-019 SHALL accept a command or beat only in a cycle where amm_read_i or amm_write_i is high and amm_waitrequest_o is low.
REQ-020 SHALL implement an FSM with states IDLE, WR_BURST and RD_BURST.
REQ-021 SHALL compute the storage index as amm_address_i[MEM_DEPTH_W-1:0]; beat k uses (index+k) mod 2^MEM_DEPTH_W, wrapping silently.
REQ-022 IDLE, accepted write with burstcount=1: SHALL write one word and remain in IDLE.
REQ-023 IDLE, accepted write with burstcount>1: SHALL write beat 0, latch the base index and remaining=burstcount-1, and go to WR_BURST.
REQ-024 WR_BURST: SHALL write each accepted beat to the next index, ignore amm_address_i and amm_burstcount_i, and return to IDLE after the last beat.
REQ-025 Writes SHALL update only the bytes whose amm_byteenable_i bit is 1.
REQ-026 IDLE, accepted read with burstcount=B: SHALL go to RD_BURST for cycles T0+1..T0+B-1, where T0 is the accept cycle; B=1 stays in IDLE.
REQ-027 Read beat k SHALL present amm_readdatavalid_o=1 with its data in cycle T0+READ_LATENCY+k, delivered in order through a READ_LATENCY-stage pipeline.
REQ-028 amm_waitrequest_o SHALL be high during RD_BURST, during reset, and, when WAITREQ_PERIOD=N>0, whenever a free-running mod-N counter equals N-1.
REQ-029 A new command SHALL be acceptable at T0+B while earlier read beats are still in the pipeline; ordering is preserved.
REQ-030 A read during WR_BURST SHALL be ignored and SHALL set protocol_err_o.
REQ-031 Burstcount 0 on a command SHALL be ignored (no write, no read, FSM unchanged) and SHALL set protocol_err_o.
REQ-032 Read and write high together in IDLE SHALL both be ignored and SHALL set protocol_err_o.
REQ-033 A write to the index being read in the same cycle SHALL return the old data.

Reset
REQ-034 While rst_i is high: amm_waitrequest_o=1, amm_readdatavalid_o=0, amm_readdata_o=0, protocol_err_o=0, FSM=IDLE, stall counter=0, read pipeline flushed.
REQ-035 amm_waitrequest_o SHALL stay high until the first rising clk_i edge after rst_i falls.
REQ-036 Reset mid-burst SHALL abandon the burst with no further writes or readdatavalid beats.
REQ-037 Storage contents SHALL NOT be affected by reset; unwritten words read as undefined.
REQ-038 protocol_err_o SHALL be cleared only by reset.

Verification (defaults unless stated)
REQ-039 Assert rst_i for 3 cycles mid-read-burst -> waitrequest=1, readdatavalid=0, protocol_err=0; no stale beats after release.
REQ-040 Write burst of 4 at 0x0010, data 1,2,3,4, byteenable 0xF; then read burst of 4 at 0x0010 accepted at T0 -> waitrequest high T0+1..T0+3; readdatavalid at T0+2..T0+5 with data 1,2,3,4.
REQ-041 Write 0xAABBCCDD, then write 0x11223344 with byteenable 0b0101 to the same address, then read -> 0xAA22CC44.
REQ-042 Write burst of 2 at 0x00FF with data 0xA,0xB, then read 1 at 0x0100 -> 0xB; read 1 at 0x0000 -> 0xB.
REQ-043 Write with burstcount 0 -> protocol_err_o=1 and stays 1; memory unchanged; clears only on rst_i.
REQ-044 WAITREQ_PERIOD=3, write held high across a stall cycle -> waitrequest high exactly one cycle in three while idle; the beat is written exactly once, on the next non-stall cycle.
